gate_tt_sequencer: RTL and testbench
====================================

// Module: gate_tt_sequencer
// PURPOSE
//   Clocked stimulus/check stage that sits directly upstream of a 2-input combinational gate (norComp).
//   It drives the gate's x/y inputs through all four input combinations, holding each one for HOLD_CYCLES.
//   It samples the gate output z at the end of each hold and compares it with a parameterised expected truth table.
//   It reports per-vector mismatches, the observed truth table, an error count and a pass flag via a start/done handshake.
// PARAMETERS
//   HOLD_CYCLES  20       cycles each vector is held; z is sampled in the last held cycle; legal range >= 1
//   EXPECT_TT    4'b0001  expected z, indexed by {x,y} (bit0 = x0y0); default is the NOR truth table
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   start      in   1  request a run; sampled only in IDLE
//   z          in   1  output of the gate under test (combinational from x,y)
//   x          out  1  gate input x, registered
//   y          out  1  gate input y, registered
//   busy       out  1  high while vectors are being driven (DRIVE state)
//   done       out  1  one-cycle pulse: run complete, results valid
//   pass       out  1  1 when err_count==0 at completion; held until next accepted start
//   mismatch   out  1  one-cycle pulse in the cycle after a sample whose z != expected
//   err_count  out  3  number of mismatching vectors in the run, 0..4
//   obs_tt     out  4  sampled z per vector, indexed by {x,y}
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): state=IDLE; x,y,busy,done,pass,mismatch=0; err_count=0; obs_tt=0; hold counter=0.
//   - Reset mid-run aborts immediately. There is no done pulse; all results are cleared.
//   - Vector order (step 0..3): {x,y} = 00, 10, 11, 01. Only one input changes per step.
//   - FSM states: IDLE, DRIVE, DONE.
//   - IDLE -> DRIVE: on an edge E0 with start=1.
//     - At E0: step=0, counter=HOLD_CYCLES-1, err_count=0, obs_tt=0, pass=0.
//     - {x,y}=00 is visible after E0.
//   - DRIVE, counter!=0: decrement the counter; x,y unchanged.
//   - DRIVE, counter==0 (sample edge):
//     - obs_tt[{x,y}] <= z.
//     - If z != EXPECT_TT[{x,y}]: err_count += 1 and mismatch=1 for the next cycle.
//     - If step<3: step+1, reload counter, drive the next vector.
//     - If step==3: go to DONE; x,y <= 0.
//   - DONE: done=1 for exactly one cycle.
//     - pass = (final err_count==0), computed including the step-3 sample.
//     - Next edge -> IDLE.
//   - Timing: samples occur at edges E0+k*HOLD_CYCLES, k=1..4.
//     - done is high in the cycle after E0+4*HOLD_CYCLES.
//     - Total start-to-done latency is 4*HOLD_CYCLES+1 edges.
//   - start is ignored in DRIVE and DONE, with no queuing. It is honoured on the first IDLE edge.
//   - busy=1 exactly while in DRIVE; busy and done are never high together.
//   - err_count, obs_tt and pass hold their values in IDLE until the next accepted start.
//   - err_count cannot exceed 4, so no saturation logic is required.
//   - Counter width = $clog2(HOLD_CYCLES+1). With HOLD_CYCLES=1, a sample occurs on every DRIVE edge.
//   - z is used only on sample edges; it may glitch between samples without effect.
// STRUCTURE
//   - Shared header gate_tt_defs.vh holds:
//     - state encodings: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2;
//     - vector-order table: localparam VEC_ORDER = 8'b01_11_10_00, indexed by step.
//   - Sub-module gate_hold_timer: load/decrement counter with a zero flag, parameterised by HOLD_CYCLES.
//   - The top module instantiates gate_hold_timer plus the FSM, vector and compare logic.
//   - The testbench instantiates norComp between the x/y outputs and the z input.
// TESTING
//   1. HOLD_CYCLES=4, norComp attached, start pulse.
//      -> x,y = 00,10,11,01, each held for 4 cycles.
//      -> done at 17 edges after start; obs_tt=4'b0001, err_count=0, pass=1, mismatch never high.
//   2. EXPECT_TT=4'b1110 with norComp attached.
//      -> four mismatch pulses, err_count=4, pass=0, obs_tt=4'b0001.
//   3. start held high continuously, HOLD_CYCLES=2.
//      -> runs back-to-back with exactly one IDLE cycle between done and the next busy.
//      -> err_count clears on each start.
//   4. rst_n=0 for 1 cycle during step 2.
//      -> next cycle: all outputs 0, state IDLE, no done pulse.
//      -> a subsequent start completes normally.
//   5. HOLD_CYCLES=1: start.
//      -> one vector per cycle; done 5 edges after start; pass=1.
//   6. z forced to 1 (gate removed).
//      -> mismatches on vectors 10, 11 and 01; err_count=3, obs_tt=4'b1111, pass=0.

Source files
------------

// File: rtl/gate_tt_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM states and
// the order in which the {x,y} input vectors are applied.
package gate_tt_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // {x,y} per step, step 0 in the low bits: 00, 10, 11, 01 (one input flips per step)
    localparam logic [7:0] VEC_ORDER = 8'b01_11_10_00;

    localparam logic [1:0] LAST_STEP = 2'd3;

    function automatic logic [1:0] vec_at(input logic [1:0] step);
        return VEC_ORDER[{step, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/gate_tt_sequencer_hold_timer.sv
// Hold timer: loads HOLD_CYCLES-1, counts down to zero and stays there.
// The zero flag marks the last cycle of a hold.
module gate_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Load has priority; otherwise decrement until zero is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/norComp.sv
// Two-input NOR gate: the combinational gate exercised by the sequencer.
module norComp (
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = ~(x | y);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: drives all four {x,y} vectors into a 2-input gate,
// samples z at the end of each hold, compares against EXPECT_TT and reports
// observed table, error count and pass flag with a start/done handshake.
module gate_tt_sequencer
    import gate_tt_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [3:0]  EXPECT_TT   = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       mismatch,
    output logic [2:0] err_count,
    output logic [3:0] obs_tt
);

    state_t     state_q, state_d;
    logic [1:0] step_q;
    logic       timer_zero;
    logic       timer_load;
    logic       sample;
    logic       accept;
    logic [1:0] cur_vec;
    logic       z_bad;
    logic [2:0] err_next;

    gate_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .zero (timer_zero)
    );

    assign cur_vec  = {x, y};
    assign z_bad    = (z != EXPECT_TT[cur_vec]);
    assign err_next = err_count + {2'b00, z_bad};
    assign busy     = (state_q == DRIVE);
    assign done     = (state_q == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, timer reload and sample strobe.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        sample     = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (timer_zero) begin
                    sample = 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Vector drive, result capture and mismatch pulse.
    // pass is resolved on the final sample edge using the updated count,
    // so it is already valid in the cycle done is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q    <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            pass      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            obs_tt    <= '0;
        end else begin
            mismatch <= 1'b0;
            if (accept) begin
                step_q    <= '0;
                {x, y}    <= vec_at(2'd0);
                err_count <= '0;
                obs_tt    <= '0;
                pass      <= 1'b0;
            end else if (sample) begin
                obs_tt[cur_vec] <= z;
                err_count       <= err_next;
                mismatch        <= z_bad;
                if (step_q == LAST_STEP) begin
                    {x, y} <= 2'b00;
                    pass   <= (err_next == '0);
                end else begin
                    step_q <= step_q + 2'd1;
                    {x, y} <= vec_at(step_q + 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench for gate_tt_sequencer: four instances with different
// parameters, each driving a norComp; expected run results are queued when
// a run is set up and compared when the instance raises done.
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start_v = '0;
    logic       force_a = 1'b0;
    logic       force_c = 1'b0;

    logic [3:0] x_w, y_w, busy_w, done_w, pass_w, mm_w, nz, z_in;
    logic [2:0] err_w [4];
    logic [3:0] obs_w [4];

    logic [1:0] sel = 2'd0;
    logic       o_x, o_y, o_busy, o_done, o_pass, o_mm;
    logic [2:0] o_err;
    logic [3:0] o_obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        int         hold;
        logic [3:0] obs;
        logic [2:0] err;
        logic       pass;
        int         mm;
    } exp_t;

    exp_t sbq[$];

    logic [1:0] order [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    gate_tt_sequencer #(.HOLD_CYCLES(4), .EXPECT_TT(4'b0001)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .z(z_in[0]),
        .x(x_w[0]), .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .mismatch(mm_w[0]), .err_count(err_w[0]), .obs_tt(obs_w[0]));
    gate_tt_sequencer #(.HOLD_CYCLES(4), .EXPECT_TT(4'b1110)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .z(z_in[1]),
        .x(x_w[1]), .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .mismatch(mm_w[1]), .err_count(err_w[1]), .obs_tt(obs_w[1]));
    gate_tt_sequencer #(.HOLD_CYCLES(2), .EXPECT_TT(4'b0001)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .z(z_in[2]),
        .x(x_w[2]), .y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .mismatch(mm_w[2]), .err_count(err_w[2]), .obs_tt(obs_w[2]));
    gate_tt_sequencer #(.HOLD_CYCLES(1), .EXPECT_TT(4'b0001)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .z(z_in[3]),
        .x(x_w[3]), .y(y_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .mismatch(mm_w[3]), .err_count(err_w[3]), .obs_tt(obs_w[3]));

    norComp g0 (.x(x_w[0]), .y(y_w[0]), .z(nz[0]));
    norComp g1 (.x(x_w[1]), .y(y_w[1]), .z(nz[1]));
    norComp g2 (.x(x_w[2]), .y(y_w[2]), .z(nz[2]));
    norComp g3 (.x(x_w[3]), .y(y_w[3]), .z(nz[3]));

    // force_* stands in for removing the gate and tying z high
    assign z_in[0] = force_a ? 1'b1 : nz[0];
    assign z_in[1] = nz[1];
    assign z_in[2] = force_c ? 1'b1 : nz[2];
    assign z_in[3] = nz[3];

    assign o_x    = x_w[sel];
    assign o_y    = y_w[sel];
    assign o_busy = busy_w[sel];
    assign o_done = done_w[sel];
    assign o_pass = pass_w[sel];
    assign o_mm   = mm_w[sel];
    assign o_err  = err_w[sel];
    assign o_obs  = obs_w[sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_run(input int s, input int h, input logic [3:0] o,
                              input logic [2:0] e, input logic p, input int m);
        exp_t item;
        item.sel = s; item.hold = h; item.obs = o; item.err = e; item.pass = p; item.mm = m;
        sbq.push_back(item);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},    o_x,    0);
        check({tag, "_y"},    o_y,    0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_pass"}, o_pass, 0);
        check({tag, "_mm"},   o_mm,   0);
        check({tag, "_err"},  o_err,  0);
        check({tag, "_obs"},  o_obs,  0);
    endtask

    // Starts the run at the head of the scoreboard from a negedge, follows it
    // cycle by cycle and compares the queued result once done is seen.
    task automatic run_and_check(input bit keep_start);
        exp_t e;
        int   n;
        int   h;
        int   mm_cnt;
        bit   seen;
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e   = sbq[0];
        sel = 2'(e.sel);
        h   = e.hold;
        start_v[sel] = 1'b1;
        n = 0; mm_cnt = 0; seen = 0;
        while (!seen && n < 4 * h + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!keep_start) start_v[sel] = 1'b0;
            if (n == 1) begin
                check("start_err_clr",  o_err,  0);
                check("start_obs_clr",  o_obs,  0);
                check("start_pass_clr", o_pass, 0);
            end
            check("busy", o_busy, 32'(n <= 4 * h));
            check("busy_done_excl", o_busy & o_done, 0);
            if (n <= 4 * h) check("vec", {o_x, o_y}, order[(n - 1) / h]);
            if (o_mm) mm_cnt++;
            if (o_done) seen = 1;
        end
        e = sbq.pop_front();
        check("done_seen", 32'(seen), 1);
        check("latency",   n, 4 * h + 1);
        check("xy_after",  {o_x, o_y}, 0);
        check("obs_tt",    o_obs, e.obs);
        check("err_count", o_err, e.err);
        check("pass",      o_pass, e.pass);
        check("mm_pulses", mm_cnt, e.mm);
    endtask

    initial begin
        sel = 2'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // NOR with matching table
        expect_run(0, 4, 4'b0001, 3'd0, 1'b1, 0);
        run_and_check(0);
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("pass_held", o_pass, 1);
        check("obs_held", o_obs, 4'b0001);

        // Inverted expectation: every vector mismatches
        expect_run(1, 4, 4'b0001, 3'd4, 1'b0, 4);
        run_and_check(0);
        @(negedge clk);

        // Gate removed, z stuck high
        force_a = 1'b1;
        expect_run(0, 4, 4'b1111, 3'd3, 1'b0, 3);
        run_and_check(0);
        @(negedge clk);
        force_a = 1'b0;

        // Reset during step 2 aborts the run
        sel = 2'd0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_vec", {o_x, o_y}, 2'b11);
        check("pre_reset_obs", o_obs, 4'b0001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("mid_reset");
        begin
            int done_cnt = 0;
            int busy_cnt = 0;
            repeat (20) begin
                @(negedge clk);
                if (o_done) done_cnt++;
                if (o_busy) busy_cnt++;
            end
            check("no_done_after_reset", done_cnt, 0);
            check("idle_after_reset", busy_cnt, 0);
        end
        expect_run(0, 4, 4'b0001, 3'd0, 1'b1, 0);
        run_and_check(0);
        @(negedge clk);

        // start held high: back-to-back runs, err_count cleared on restart
        force_c = 1'b1;
        expect_run(2, 2, 4'b1111, 3'd3, 1'b0, 3);
        run_and_check(1);
        force_c = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", o_busy, 0);
        check("b2b_idle_done", o_done, 0);
        check("b2b_err_held", o_err, 3);
        expect_run(2, 2, 4'b0001, 3'd0, 1'b1, 0);
        run_and_check(1);
        start_v[2] = 1'b0;
        @(negedge clk);

        // Single-cycle hold
        expect_run(3, 1, 4'b0001, 3'd0, 1'b1, 0);
        run_and_check(0);
        @(negedge clk);

        check("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
